// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit.
// Moore-style sequencer for the shared datapath. It decodes the opcode held
// in the instruction register, stalls on the memory ready handshake and
// counts retired instructions.
module multicycle_control #(
    parameter int COUNT_W         = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               iord,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic [3:0]         state,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    state_t             state_reg;
    state_t             state_next;
    logic [COUNT_W-1:0] count_reg;
    logic               retire;

    assign state       = state_reg;
    assign instr_count = count_reg;

    // State register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire) begin
                count_reg <= count_reg + COUNT_W'(1);
            end
        end
    end

    // Next-state decode and per-state control strobes; reset masks every strobe.
    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        illegal    = 1'b0;

        case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR and PC only latch once the fetch data is actually valid.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target while decoding.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:      state_next = S_EXECUTE;
                    OP_LW, OP_SW:  state_next = S_MEM_ADDR;
                    OP_BEQ:        state_next = S_BRANCH;
                    OP_J:          state_next = S_JUMP;
                    OP_ADDI:       state_next = S_ADDI_EXEC;
                    default: begin
                        if (HALT_ON_ILLEGAL) begin
                            state_next = S_HALT;
                        end else begin
                            state_next = S_FETCH;
                            illegal    = 1'b1;
                        end
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_source  = 2'b01;
                pc_write   = zero;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                illegal    = 1'b1;
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            iord       = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            pc_source  = 2'b00;
            illegal    = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the shared datapath of the multicycle MIPS core: register file, ALU, instruction register, PC and unified memory.
- Decodes the 6-bit opcode held in the instruction register.
- Produces per-cycle control strobes, including the register-file write enable and write-destination select.
- Waits on a memory ready handshake, and counts retired instructions.

Parameters:
- COUNT_W, 16, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1, 1 = illegal opcode parks in HALT until reset; 0 = pulse illegal for one cycle and return to FETCH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  instruction[31:26] from instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_write  output  1  PC load enable.
- ir_write  output  1  instruction register load enable.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write data select: 0 = ALUOut, 1 = MDR.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  output  4  current state encoding (debug).
- illegal  output  1  unsupported opcode detected.
- instr_count  output  COUNT_W  retired instructions, wraps modulo 2^COUNT_W.

Behaviour:
- Reset behaviour:
  - While reset is high at a clock edge: state <= FETCH (0), instr_count <= 0.
  - While reset is asserted, all control outputs are forced to 0 combinationally, including illegal.
  - reset mid-instruction aborts it: no reg_write or mem_write is issued after the edge.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, HALT=12. Codes 13-15 go to FETCH.
- Outputs are a function of state only, except where noted; unlisted outputs are 0.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=mem_ready and pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode:
    - 0x00 -> EXECUTE
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> ADDI_EXEC
    - anything else -> HALT if HALT_ON_ILLEGAL, else FETCH with illegal=1 for this one cycle.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_READ if opcode=0x23, else MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Holds until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next is FETCH.
- MEM_WRITE: mem_write=1, iord=1. Holds until mem_ready=1, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next is R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write=zero (combinational). Next is FETCH.
- JUMP: pc_source=10, pc_write=1. Next is FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next is ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next is FETCH.
- HALT: illegal=1, all strobes 0. Stays until reset.
- Retirement:
  - instr_count increments by 1 on the edge leaving MEM_WB, R_WB, BRANCH, JUMP or ADDI_WB.
  - It also increments on the edge leaving MEM_WRITE with mem_ready=1.
  - Wraps from all-ones to 0. Illegal instructions never count.
- Latency, in cycles with mem_ready constantly 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- Each memory wait cycle adds 1.
- reg_write and mem_write are never both 1. reg_write is asserted for exactly one cycle per lw/R/addi.

Test Plan:
- reset=1 for 2 cycles, then opcode=0x00, mem_ready=1 -> states 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7. instr_count=1.
- lw (0x23), mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_READ -> 10 total cycles. mem_to_reg=1 in the write cycle; instr_count increments once.
- beq (0x04) with zero=1, then with zero=0 -> pc_write=1 with pc_source=01 in BRANCH for the first; pc_write=0 for the second. Both take 3 cycles.
- opcode=0x3F with HALT_ON_ILLEGAL=1 -> state=12, illegal=1 held for 20 cycles, instr_count unchanged. reset returns to state 0. With HALT_ON_ILLEGAL=0: illegal is a 1-cycle pulse, then FETCH.
- COUNT_W=4, retire 17 j instructions (0x02) -> instr_count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
- sw (0x2B) with reset asserted in MEM_WRITE while mem_ready=0 -> mem_write=0 from the reset cycle on, state=0, no count.
